sdram_cache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between a 32-bit CPU-side port and a Gowin `SDRAM_Controller_HS_Top`-style SDRAM controller driving an mt48lc2m32b2 (2M×32, 4 banks). Hits are served in zero wait cycles. Misses fill a whole line via one SDRAM burst, after writing back the victim line if it is dirty. The block also issues periodic auto-refresh.

---
 rtl/sdram_cache_pkg.sv | 27 ++
 rtl/sdram_cache_line_ram.sv | 57 +++++
 rtl/sdram_cache.sv | 195 +++++++++++++++++++
 tb/tb_sdram_cache.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_cache_pkg.sv
// Shared types and constants for the direct-mapped write-back SDRAM cache.
package sdram_cache_pkg;

  typedef enum logic [2:0] {
    S_INIT          = 3'd0,
    S_REFRESH       = 3'd1,
    S_IDLE          = 3'd2,
    S_WB_ACTIVATE   = 3'd3,
    S_WB_WRITE      = 3'd4,
    S_FILL_ACTIVATE = 3'd5,
    S_FILL_READ     = 3'd6
  } state_t;

  localparam logic [2:0] CMD_ACTIVATE = 3'b011;
  localparam logic [2:0] CMD_READ     = 3'b101;
  localparam logic [2:0] CMD_WRITE    = 3'b100;
  localparam logic [2:0] CMD_REFRESH  = 3'b001;

  localparam int unsigned LineWords        = 8;
  localparam int unsigned OffsetBits       = 3;
  localparam int unsigned ReadDataDelay    = 4;
  localparam int unsigned RefreshInterval  = 700;
  localparam int unsigned SdramAddrBits    = 21;
  localparam int unsigned RefreshCountBits = $clog2(RefreshInterval);
  localparam int unsigned BeatBits         = $clog2(ReadDataDelay + LineWords + 1);

endpackage

// File: rtl/sdram_cache_line_ram.sv
// Per-line valid/dirty/tag and line data; asynchronous read, byte-strobed write.
module sdram_cache_line_ram
  import sdram_cache_pkg::*;
#(
  parameter int unsigned IndexBits = 1,
  parameter int unsigned TagBits   = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IndexBits-1:0] index,
  input  logic [2:0]           rd_offset,
  output logic [31:0]          rd_data,
  output logic                 line_valid,
  output logic                 line_dirty,
  output logic [TagBits-1:0]   line_tag,
  input  logic                 wr_en,
  input  logic [2:0]           wr_offset,
  input  logic [3:0]           wr_strobe,
  input  logic [31:0]          wr_data,
  input  logic                 meta_wr,
  input  logic                 meta_dirty,
  input  logic [TagBits-1:0]   meta_tag
);

  localparam int unsigned Lines = 1 << IndexBits;

  logic [31:0]        data  [Lines*LineWords];
  logic [TagBits-1:0] tag   [Lines];
  logic [Lines-1:0]   valid;
  logic [Lines-1:0]   dirty;

  assign rd_data    = data[{index, rd_offset}];
  assign line_valid = valid[index];
  assign line_dirty = dirty[index];
  assign line_tag   = tag[index];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (meta_wr) begin
      valid[index] <= 1'b1;
      dirty[index] <= meta_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (meta_wr) tag[index] <= meta_tag;
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && wr_strobe[b]) data[{index, wr_offset}][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

endmodule

// File: rtl/sdram_cache.sv
// Direct-mapped write-back/write-allocate cache in front of an SDRAM controller,
// with zero-wait hits, burst line fill/write-back and periodic auto-refresh.
module sdram_cache
  import sdram_cache_pkg::*;
#(
  parameter int unsigned LineIndexBitWidth  = 1,
  parameter int unsigned RamAddressBitWidth = 21,
  parameter int unsigned RamAddressingMode  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] address,
  output logic [31:0] data_out,
  output logic        data_out_ready,
  input  logic [31:0] data_in,
  input  logic [3:0]  write_enable,
  output logic        busy,
  output logic        I_sdrc_cmd_en,
  output logic [2:0]  I_sdrc_cmd,
  output logic        I_sdrc_precharge_ctrl,
  output logic        I_sdram_power_down,
  output logic        I_sdram_selfrefresh,
  output logic [20:0] I_sdrc_addr,
  output logic [3:0]  I_sdrc_dqm,
  output logic [31:0] I_sdrc_data,
  output logic [7:0]  I_sdrc_data_len,
  input  logic [31:0] O_sdrc_data,
  input  logic        O_sdrc_init_done,
  input  logic        O_sdrc_cmd_ack
);

  localparam int unsigned TagBits = RamAddressBitWidth - OffsetBits - LineIndexBitWidth;

  state_t                        state;
  logic [RefreshCountBits-1:0]   refresh_count;
  logic                          refresh_pending;
  logic [BeatBits-1:0]           beat;
  logic                          data_phase;

  logic [RamAddressBitWidth-1:0] word_addr;
  logic [2:0]                    offset;
  logic [LineIndexBitWidth-1:0]  index;
  logic [TagBits-1:0]            tag;
  logic [31:0]                   rd_data;
  logic                          line_valid, line_dirty;
  logic [TagBits-1:0]            line_tag;
  logic                          hit, idle, read_hit, write_hit;
  logic                          fill_capture, fill_last;
  logic [2:0]                    rd_offset;
  logic [SdramAddrBits-1:0]      victim_line, request_line;

  // Upper address bits beyond the SDRAM word space are discarded here.
  assign word_addr    = RamAddressBitWidth'(address >> RamAddressingMode);
  assign offset       = word_addr[2:0];
  assign index        = word_addr[OffsetBits +: LineIndexBitWidth];
  assign tag          = word_addr[RamAddressBitWidth-1 -: TagBits];
  assign victim_line  = SdramAddrBits'({line_tag, index, 3'b000});
  assign request_line = SdramAddrBits'({tag, index, 3'b000});

  assign hit       = line_valid && (line_tag == tag);
  assign idle      = (state == S_IDLE);
  assign read_hit  = idle && enable && hit && (write_enable == 4'b0000);
  assign write_hit = idle && enable && hit && (write_enable != 4'b0000);

  assign busy           = !idle || (enable && !hit);
  assign data_out_ready = read_hit;
  assign data_out       = read_hit ? rd_data : 32'd0;

  // Fill words arrive ReadDataDelay..ReadDataDelay+7 cycles after the READ ack.
  assign fill_capture = (state == S_FILL_READ) && data_phase &&
                        (beat >= BeatBits'(ReadDataDelay)) &&
                        (beat <= BeatBits'(ReadDataDelay + LineWords - 1));
  assign fill_last    = fill_capture && (beat == BeatBits'(ReadDataDelay + LineWords - 1));
  assign rd_offset    = (state == S_WB_WRITE) ? (data_phase ? beat[2:0] : 3'd0) : offset;

  assign I_sdrc_precharge_ctrl = 1'b1;
  assign I_sdram_power_down    = 1'b0;
  assign I_sdram_selfrefresh   = 1'b0;
  assign I_sdrc_dqm            = 4'b0000;
  assign I_sdrc_data_len       = 8'(LineWords - 1);

  sdram_cache_line_ram #(
    .IndexBits (LineIndexBitWidth),
    .TagBits   (TagBits)
  ) u_line_ram (
    .clk        (clk),
    .rst        (rst),
    .index      (index),
    .rd_offset  (rd_offset),
    .rd_data    (rd_data),
    .line_valid (line_valid),
    .line_dirty (line_dirty),
    .line_tag   (line_tag),
    .wr_en      (write_hit || fill_capture),
    .wr_offset  (fill_capture ? 3'(beat - BeatBits'(ReadDataDelay)) : offset),
    .wr_strobe  (fill_capture ? 4'b1111 : write_enable),
    .wr_data    (fill_capture ? O_sdrc_data : data_in),
    .meta_wr    (write_hit || fill_last),
    .meta_dirty (write_hit),
    .meta_tag   (tag)
  );

  // Controller sequencing, refresh scheduling and burst streaming.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_INIT;
      I_sdrc_cmd_en   <= 1'b0;
      I_sdrc_cmd      <= 3'b000;
      I_sdrc_addr     <= '0;
      I_sdrc_data     <= '0;
      beat            <= '0;
      data_phase      <= 1'b0;
      refresh_count   <= '0;
      refresh_pending <= 1'b0;
    end else begin
      I_sdrc_cmd_en <= 1'b0;
      case (state)
        S_INIT: if (O_sdrc_init_done) state <= S_IDLE;
        S_REFRESH: if (O_sdrc_cmd_ack) state <= S_IDLE;
        S_IDLE: begin
          if (refresh_pending) begin
            I_sdrc_cmd      <= CMD_REFRESH;
            I_sdrc_cmd_en   <= 1'b1;
            refresh_pending <= 1'b0;
            state           <= S_REFRESH;
          end else if (enable && !hit) begin
            I_sdrc_cmd    <= CMD_ACTIVATE;
            I_sdrc_cmd_en <= 1'b1;
            if (line_valid && line_dirty) begin
              I_sdrc_addr <= victim_line;
              state       <= S_WB_ACTIVATE;
            end else begin
              I_sdrc_addr <= request_line;
              state       <= S_FILL_ACTIVATE;
            end
          end
        end
        S_WB_ACTIVATE: if (O_sdrc_cmd_ack) begin
          I_sdrc_cmd    <= CMD_WRITE;
          I_sdrc_cmd_en <= 1'b1;
          data_phase    <= 1'b0;
          state         <= S_WB_WRITE;
        end
        S_WB_WRITE: begin
          if (!data_phase) begin
            if (O_sdrc_cmd_ack) begin
              data_phase  <= 1'b1;
              beat        <= BeatBits'(1);
              I_sdrc_data <= rd_data;
            end
          end else if (beat == BeatBits'(LineWords)) begin
            data_phase    <= 1'b0;
            I_sdrc_cmd    <= CMD_ACTIVATE;
            I_sdrc_cmd_en <= 1'b1;
            I_sdrc_addr   <= request_line;
            state         <= S_FILL_ACTIVATE;
          end else begin
            I_sdrc_data <= rd_data;
            beat        <= beat + 1'b1;
          end
        end
        S_FILL_ACTIVATE: if (O_sdrc_cmd_ack) begin
          I_sdrc_cmd    <= CMD_READ;
          I_sdrc_cmd_en <= 1'b1;
          data_phase    <= 1'b0;
          state         <= S_FILL_READ;
        end
        S_FILL_READ: begin
          if (!data_phase) begin
            if (O_sdrc_cmd_ack) begin
              data_phase <= 1'b1;
              beat       <= BeatBits'(1);
            end
          end else begin
            beat <= beat + 1'b1;
            if (fill_last) begin
              data_phase <= 1'b0;
              state      <= S_IDLE;
            end
          end
        end
        default: state <= S_INIT;
      endcase
      // Placed after the FSM so a wrap coinciding with an issue keeps the new request.
      if (refresh_count == RefreshCountBits'(RefreshInterval - 1)) begin
        refresh_count   <= '0;
        refresh_pending <= 1'b1;
      end else begin
        refresh_count <= refresh_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_cache.sv
// Bench for sdram_cache: behavioural SDRAM controller, flat-memory reference cache
// model, the directed access plan and randomized accesses.
module tb_sdram_cache;

  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_REF = 3'b001;
  localparam int RD_DELAY = sdram_cache_pkg::ReadDataDelay;
  localparam int WORDS = 128;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [31:0] address, data_in, data_out;
  logic [3:0]  write_enable;
  logic        data_out_ready, busy;
  logic        I_sdrc_cmd_en, I_sdrc_precharge_ctrl, I_sdram_power_down, I_sdram_selfrefresh;
  logic [2:0]  I_sdrc_cmd;
  logic [20:0] I_sdrc_addr;
  logic [3:0]  I_sdrc_dqm;
  logic [31:0] I_sdrc_data, O_sdrc_data;
  logic [7:0]  I_sdrc_data_len;
  logic        O_sdrc_init_done, O_sdrc_cmd_ack;

  int tests = 0;
  int fails = 0;
  int n_refresh = 0, n_write_burst = 0, n_read_burst = 0;

  logic [31:0] sdram_mem [WORDS];
  logic [31:0] ref_mem   [WORDS];
  logic        ref_valid [2];
  logic        ref_dirty [2];
  int          ref_tag   [2];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  we;
    logic [31:0] exp;
    logic        miss;
    logic        wb;
  } step_t;
  step_t plan [10];

  always #5 clk = ~clk;

  sdram_cache #(
    .LineIndexBitWidth  (1),
    .RamAddressBitWidth (7),
    .RamAddressingMode  (2)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .enable                (enable),
    .address               (address),
    .data_out              (data_out),
    .data_out_ready        (data_out_ready),
    .data_in               (data_in),
    .write_enable          (write_enable),
    .busy                  (busy),
    .I_sdrc_cmd_en         (I_sdrc_cmd_en),
    .I_sdrc_cmd            (I_sdrc_cmd),
    .I_sdrc_precharge_ctrl (I_sdrc_precharge_ctrl),
    .I_sdram_power_down    (I_sdram_power_down),
    .I_sdram_selfrefresh   (I_sdram_selfrefresh),
    .I_sdrc_addr           (I_sdrc_addr),
    .I_sdrc_dqm            (I_sdrc_dqm),
    .I_sdrc_data           (I_sdrc_data),
    .I_sdrc_data_len       (I_sdrc_data_len),
    .O_sdrc_data           (O_sdrc_data),
    .O_sdrc_init_done      (O_sdrc_init_done),
    .O_sdrc_cmd_ack        (O_sdrc_cmd_ack)
  );

  // Behavioural controller: random ack latency, 8-word bursts against sdram_mem.
  initial begin : ctrl_model
    logic [2:0] c;
    int base, lat;
    O_sdrc_cmd_ack = 1'b0;
    O_sdrc_data = 32'd0;
    @(negedge clk);
    forever begin
      if (I_sdrc_cmd_en !== 1'b1) @(negedge clk);
      else begin
        c = I_sdrc_cmd;
        base = int'(I_sdrc_addr);
        lat = $urandom_range(1, 3);
        if (c == C_REF) n_refresh++;
        if (c == C_WR) n_write_burst++;
        if (c == C_RD) n_read_burst++;
        if (c == C_RD || c == C_WR) begin
          tests++;
          if (base % 8 != 0 || base + 7 >= WORDS) begin
            fails++;
            $display("FAIL burst_addr: got %0d want line-aligned below %0d", base, WORDS);
            base = 0;
          end
        end
        @(negedge clk);
        tests++;
        if (I_sdrc_cmd_en !== 1'b0) begin
          fails++;
          $display("FAIL cmd_en_pulse: got %b want 0 one cycle after strobe", I_sdrc_cmd_en);
        end
        repeat (lat - 1) @(negedge clk);
        tests++;
        if (I_sdrc_cmd !== c) begin
          fails++;
          $display("FAIL cmd_hold: got %b want %b until ack", I_sdrc_cmd, c);
        end
        O_sdrc_cmd_ack = 1'b1;
        @(negedge clk);
        O_sdrc_cmd_ack = 1'b0;
        if (c == C_WR) begin
          for (int k = 0; k < 8; k++) begin
            sdram_mem[base + k] = I_sdrc_data;
            if (k < 7) @(negedge clk);
          end
        end else if (c == C_RD) begin
          repeat (RD_DELAY - 1) @(negedge clk);
          for (int k = 0; k < 8; k++) begin
            O_sdrc_data = sdram_mem[base + k];
            if (k < 7) @(negedge clk);
          end
        end
      end
    end
  end

  // Reference cache: predicts hit/write-back and the CPU-visible word.
  function automatic void model_access(input logic [31:0] addr, input logic [31:0] wd,
                                       input logic [3:0] we, output logic hit,
                                       output logic wb, output logic [31:0] rdata);
    int w, idx, tg;
    w = int'((addr >> 2) % 32'(WORDS));
    idx = (w / 8) % 2;
    tg = w / 16;
    hit = ref_valid[idx] && ref_tag[idx] == tg;
    wb = !hit && ref_valid[idx] && ref_dirty[idx];
    if (!hit) ref_dirty[idx] = 1'b0;
    ref_valid[idx] = 1'b1;
    ref_tag[idx] = tg;
    for (int b = 0; b < 4; b++) if (we[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
    if (we != 4'b0000) ref_dirty[idx] = 1'b1;
    rdata = ref_mem[w];
  endfunction

  task automatic access(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] we,
                        output logic first_busy, output logic first_rdy, output logic [31:0] rd,
                        output logic rdy, output logic done, output int refs, output int wbs,
                        output int fills);
    int r0, w0, f0, n;
    r0 = n_refresh; w0 = n_write_burst; f0 = n_read_burst;
    @(negedge clk);
    enable = 1'b1; address = addr; data_in = wd; write_enable = we;
    #1;
    first_busy = busy; first_rdy = data_out_ready;
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clk); #1; n++;
    end
    done = (busy === 1'b0);
    rd = data_out; rdy = data_out_ready;
    @(posedge clk); #1;
    enable = 1'b0; write_enable = 4'b0000;
    refs = n_refresh - r0; wbs = n_write_burst - w0; fills = n_read_burst - f0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; enable = 1'b1; address = 32'd0; data_in = 32'd0; write_enable = 4'b0000;
    O_sdrc_init_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || data_out_ready !== 1'b0 || I_sdrc_cmd_en !== 1'b0 ||
        I_sdrc_cmd !== 3'b000 || data_out !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b rdy=%b cmd_en=%b cmd=%b dout=%h want 1 0 0 000 0",
               busy, data_out_ready, I_sdrc_cmd_en, I_sdrc_cmd, data_out);
    end
    tests++;
    if (I_sdrc_precharge_ctrl !== 1'b1 || I_sdram_power_down !== 1'b0 ||
        I_sdram_selfrefresh !== 1'b0 || I_sdrc_dqm !== 4'd0 || I_sdrc_data_len !== 8'd7) begin
      fails++;
      $display("FAIL constants: got pc=%b pd=%b sr=%b dqm=%h len=%0d want 1 0 0 0 7",
               I_sdrc_precharge_ctrl, I_sdram_power_down, I_sdram_selfrefresh,
               I_sdrc_dqm, I_sdrc_data_len);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (dut.state !== 3'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL init_wait: got state=%0d busy=%b want 0 1", dut.state, busy);
    end
    enable = 1'b0;
    O_sdrc_init_done = 1'b1;
    n = 0;
    while (dut.state !== 3'd2 && n < 50) begin @(negedge clk); n++; end
    tests++;
    if (dut.state !== 3'd2 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reach_idle: got state=%0d busy=%b want 2 0", dut.state, busy);
    end
  endtask

  task automatic test_sequential_fill();
    logic fb, fr, rdy, done, eh, ew;
    logic [31:0] rd, er;
    int refs, wbs, fills, bad;
    bad = 0;
    for (int i = 0; i < WORDS; i++) begin
      model_access(32'(4 * i), 32'(i), 4'hf, eh, ew, er);
      access(32'(4 * i), 32'(i), 4'hf, fb, fr, rd, rdy, done, refs, wbs, fills);
      tests++;
      if (!done || wbs != int'(ew) || fills != int'(!eh) || rdy !== 1'b0) begin
        fails++; bad++;
        if (bad < 4)
          $display("FAIL seq_write[%0d]: got done=%b wb=%0d fill=%0d rdy=%b want 1 %0d %0d 0",
                   i, done, wbs, fills, rdy, ew, !eh);
      end
    end
  endtask

  task automatic test_plan_steps();
    logic fb, fr, rdy, done, eh, ew;
    logic [31:0] rd, er;
    int refs, wbs, fills;
    plan[0] = '{32'd4,  32'd0,         4'h0, 32'd1,         1'b1, 1'b1};
    plan[1] = '{32'd8,  32'd0,         4'h0, 32'd2,         1'b0, 1'b0};
    plan[2] = '{32'd4,  32'hABCD1234,  4'hF, 32'd0,         1'b0, 1'b0};
    plan[3] = '{32'd4,  32'd0,         4'h0, 32'hABCD1234,  1'b0, 1'b0};
    plan[4] = '{32'd64, 32'd0,         4'h0, 32'd16,        1'b1, 1'b1};
    plan[5] = '{32'd12, 32'd0,         4'h0, 32'd3,         1'b1, 1'b0};
    plan[6] = '{32'd64, 32'hF55E1234,  4'hF, 32'd0,         1'b1, 1'b0};
    plan[7] = '{32'd64, 32'd0,         4'h0, 32'hF55E1234,  1'b0, 1'b0};
    plan[8] = '{32'd4,  32'd0,         4'h0, 32'hABCD1234,  1'b1, 1'b1};
    plan[9] = '{32'd64, 32'd0,         4'h0, 32'hF55E1234,  1'b1, 1'b0};
    for (int s = 0; s < 10; s++) begin
      model_access(plan[s].addr, plan[s].wd, plan[s].we, eh, ew, er);
      access(plan[s].addr, plan[s].wd, plan[s].we, fb, fr, rd, rdy, done, refs, wbs, fills);
      tests++;
      if (!done) begin
        fails++; $display("FAIL plan_timeout[%0d]: got busy stuck want done", s);
      end
      tests++;
      if (plan[s].miss ? (fb !== 1'b1 || fr !== 1'b0) : (refs == 0 && fb !== 1'b0)) begin
        fails++;
        $display("FAIL plan_first_cycle[%0d]: got busy=%b rdy=%b want miss=%b", s, fb, fr, plan[s].miss);
      end
      tests++;
      if (wbs != int'(plan[s].wb) || fills != int'(plan[s].miss)) begin
        fails++;
        $display("FAIL plan_bursts[%0d]: got wb=%0d fill=%0d want %0d %0d",
                 s, wbs, fills, plan[s].wb, plan[s].miss);
      end
      tests++;
      if (plan[s].we == 4'h0 ? (rdy !== 1'b1 || rd !== plan[s].exp) : (rdy !== 1'b0)) begin
        fails++;
        $display("FAIL plan_data[%0d]: got rdy=%b data=%h want data=%h", s, rdy, rd, plan[s].exp);
      end
    end
  endtask

  task automatic test_refresh();
    logic fb, fr, rdy, done, eh, ew;
    logic [31:0] rd, er;
    int refs, wbs, fills, r0;
    r0 = n_refresh;
    repeat (1500) @(posedge clk);
    tests++;
    if (n_refresh - r0 < 2 || n_refresh - r0 > 3) begin
      fails++;
      $display("FAIL refresh_count: got %0d want 2..3 over 1500 idle cycles", n_refresh - r0);
    end
    model_access(32'd64, 32'd0, 4'h0, eh, ew, er);
    access(32'd64, 32'd0, 4'h0, fb, fr, rd, rdy, done, refs, wbs, fills);
    tests++;
    if (!done || rdy !== 1'b1 || rd !== 32'hF55E1234 || fills != 0) begin
      fails++;
      $display("FAIL refresh_keep_64: got done=%b rdy=%b data=%h fill=%0d want 1 1 f55e1234 0",
               done, rdy, rd, fills);
    end
    model_access(32'd4, 32'd0, 4'h0, eh, ew, er);
    access(32'd4, 32'd0, 4'h0, fb, fr, rd, rdy, done, refs, wbs, fills);
    tests++;
    if (!done || rdy !== 1'b1 || rd !== 32'hABCD1234 || wbs != 0) begin
      fails++;
      $display("FAIL refresh_keep_4: got done=%b rdy=%b data=%h wb=%0d want 1 1 abcd1234 0",
               done, rdy, rd, wbs);
    end
  endtask

  task automatic test_random();
    logic fb, fr, rdy, done, eh, ew;
    logic [31:0] rd, er, addr, wd;
    logic [3:0] we;
    int refs, wbs, fills, bad;
    bad = 0;
    addr = 32'd0;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 1) == 1) addr = addr ^ 32'($urandom_range(0, 31));
      else addr = $urandom;
      wd = $urandom;
      we = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      model_access(addr, wd, we, eh, ew, er);
      access(addr, wd, we, fb, fr, rd, rdy, done, refs, wbs, fills);
      tests++;
      if (!done || wbs != int'(ew) || fills != int'(!eh) ||
          (!eh && (fb !== 1'b1 || fr !== 1'b0)) || (eh && refs == 0 && fb !== 1'b0) ||
          (we == 4'h0 && (rdy !== 1'b1 || rd !== er)) || (we != 4'h0 && rdy !== 1'b0)) begin
        fails++; bad++;
        if (bad < 6)
          $display("FAIL random[%0d] addr=%h we=%h: got done=%b fb=%b wb=%0d fill=%0d rdy=%b data=%h want hit=%b wb=%b data=%h",
                   i, addr, we, done, fb, wbs, fills, rdy, rd, eh, ew, er);
      end
    end
  endtask

  task automatic test_backing_store();
    int bad, first, idx, tg;
    bad = 0; first = -1;
    for (int w = 0; w < WORDS; w++) begin
      idx = (w / 8) % 2;
      tg = w / 16;
      if (!(ref_valid[idx] && ref_tag[idx] == tg && ref_dirty[idx]) && sdram_mem[w] !== ref_mem[w]) begin
        bad++;
        if (first < 0) first = w;
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL backing_store: got %0d stale words (first %0d: %h) want %h",
               bad, first, sdram_mem[first], ref_mem[first]);
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      sdram_mem[i] = $urandom;
      ref_mem[i] = sdram_mem[i];
    end
    for (int i = 0; i < 2; i++) begin
      ref_valid[i] = 1'b0; ref_dirty[i] = 1'b0; ref_tag[i] = 0;
    end
    test_reset();
    test_sequential_fill();
    test_plan_steps();
    test_refresh();
    test_random();
    test_backing_store();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
